// File: rtl/rt_pkg.sv
// Shared record types, constants and halfword packing for the ray-result writer.
package rt_pkg;

   localparam int REC_BYTES  = 12;
   localparam int REC_HWORDS = 6;

   localparam logic [31:0] MISS_T   = 32'h7FFF_FFFF;
   localparam logic [31:0] MISS_IDX = 32'hFFFF_FFFF;

   typedef struct packed {
      logic               hit;
      logic signed [31:0] t;
      logic [31:0]        idx;
   } hit_rec_t;

   // Little-endian halfword k of a 12-byte record.
   function automatic logic [15:0] rec_hword(input hit_rec_t rec, input logic [2:0] k);
      logic [15:0] hw;
      case (k)
         3'd0:    hw = {15'd0, rec.hit};
         3'd1:    hw = 16'd0;
         3'd2:    hw = rec.t[15:0];
         3'd3:    hw = rec.t[31:16];
         3'd4:    hw = rec.idx[15:0];
         3'd5:    hw = rec.idx[31:16];
         default: hw = 16'd0;
      endcase
      return hw;
   endfunction

endpackage

// File: rtl/hit_fifo.sv
// Synchronous result FIFO of hit_rec_t with registered full/empty flags.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module hit_fifo
   import rt_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     flush,
   input  logic     push,
   input  hit_rec_t din,
   input  logic     pop,
   output hit_rec_t dout,
   output logic     full,
   output logic     empty
);

   localparam int PTR_W = $clog2(DEPTH);

   hit_rec_t         mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic [PTR_W:0]   count_nxt_s;
   logic             full_r;
   logic             empty_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign do_pop_s  = pop && !empty_r;
   assign do_push_s = push && (!full_r || do_pop_s);

   // Occupancy after this cycle's push/pop.
   always_comb begin
      count_nxt_s = count_r;
      case ({do_push_s, do_pop_s})
         2'b10:   count_nxt_s = count_r + (PTR_W+1)'(1);
         2'b01:   count_nxt_s = count_r - (PTR_W+1)'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointers, occupancy and flags; flush wins over push/pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == (PTR_W+1)'(DEPTH));
         empty_r <= (count_nxt_s == (PTR_W+1)'(0));
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push_s && !flush) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   assign dout  = mem_r[rd_ptr_r];
   assign full  = full_r;
   assign empty = empty_r;

endmodule

// File: rtl/hit_writer.sv
// Buffers closest-hit results and writes each as a 12-byte record over a 16-bit Avalon-MM master.
// Build option HIT_WRITER_COMPACT_MISS_EN: miss records write only halfwords 0 and 1.
module hit_writer
   import rt_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_baseaddr,
   input  logic [31:0]       i_ray_cnt,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_hit,
   input  logic [31:0]       i_t,
   input  logic [31:0]       i_tri_index,
   output logic              o_done,
   output logic              avm_m0_write,
   output logic [ADDR_W-1:0] avm_m0_address,
   output logic [15:0]       avm_m0_writedata,
   output logic [1:0]        avm_m0_byteenable,
   input  logic              avm_m0_waitrequest
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_NEXT  = 2'd2;

`ifdef HIT_WRITER_COMPACT_MISS_EN
   localparam logic COMPACT_MISS = 1'b1;
`else
   localparam logic COMPACT_MISS = 1'b0;
`endif

   logic [1:0]        state_r;
   logic [2:0]        k_r;
   hit_rec_t          rec_r;
   logic [ADDR_W-1:0] rec_addr_r;
   logic [31:0]       ray_cnt_r;
   logic [31:0]       ray_count_r;
   logic              done_r;
   logic              abort_pend_r;
   logic              dbg_overflow_unused_r;
   logic              write_r;
   logic [ADDR_W-1:0] addr_r;
   logic [15:0]       wdata_r;
   logic [1:0]        be_r;

   hit_rec_t          push_rec_s;
   hit_rec_t          fifo_dout_s;
   hit_rec_t          pop_rec_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic              push_s;
   logic              pop_s;
   logic              accept_s;
   logic              last_hw_s;
   logic              leave_s;
   logic [2:0]        last_k_s;

   assign push_rec_s = '{hit: i_hit, t: i_t, idx: i_tri_index};
   assign push_s     = i_valid && !i_start;
   assign pop_s      = (state_r == ST_IDLE) && !fifo_empty_s && !done_r && !i_start;
   assign accept_s   = write_r && !avm_m0_waitrequest;
   assign last_hw_s  = (k_r == last_k_s);
   assign leave_s    = i_start || abort_pend_r;

   hit_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (i_start),
      .push  (push_s),
      .din   (push_rec_s),
      .pop   (pop_s),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Miss substitution on pop and the final halfword index of the current record.
   always_comb begin
      pop_rec_s = fifo_dout_s;
      if (!fifo_dout_s.hit) begin
         pop_rec_s.t   = MISS_T;
         pop_rec_s.idx = MISS_IDX;
      end else begin
         pop_rec_s = fifo_dout_s;
      end
      if (COMPACT_MISS && !rec_r.hit) begin
         last_k_s = 3'd1;
      end else begin
         last_k_s = 3'(REC_HWORDS - 1);
      end
   end

   // Frame control, record FSM and the registered Avalon master outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r               <= ST_IDLE;
         k_r                   <= 3'd0;
         rec_r                 <= '0;
         rec_addr_r            <= '0;
         ray_cnt_r             <= 32'd0;
         ray_count_r           <= 32'd0;
         done_r                <= 1'b0;
         abort_pend_r          <= 1'b0;
         dbg_overflow_unused_r <= 1'b0;
         write_r               <= 1'b0;
         addr_r                <= '0;
         wdata_r               <= 16'd0;
         be_r                  <= 2'b00;
      end else begin
         if (i_start) begin
            rec_addr_r  <= i_baseaddr;
            ray_cnt_r   <= i_ray_cnt;
            ray_count_r <= 32'd0;
            done_r      <= (i_ray_cnt == 32'd0);
         end
         if (i_valid && !i_start && fifo_full_s && !pop_s) begin
            dbg_overflow_unused_r <= 1'b1;
         end
         case (state_r)
            ST_IDLE: begin
               if (pop_s) begin
                  rec_r   <= pop_rec_s;
                  k_r     <= 3'd0;
                  write_r <= 1'b1;
                  addr_r  <= rec_addr_r;
                  wdata_r <= rec_hword(pop_rec_s, 3'd0);
                  be_r    <= 2'b11;
                  state_r <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               // A restart may not cut a halfword short; it takes effect once the slave accepts.
               if (accept_s) begin
                  if (leave_s || last_hw_s) begin
                     write_r      <= 1'b0;
                     be_r         <= 2'b00;
                     abort_pend_r <= 1'b0;
                     if (leave_s) begin
                        state_r <= ST_IDLE;
                     end else begin
                        done_r  <= (ray_count_r + 32'd1 == ray_cnt_r);
                        state_r <= ST_NEXT;
                     end
                  end else begin
                     k_r     <= k_r + 3'd1;
                     addr_r  <= addr_r + ADDR_W'(2);
                     wdata_r <= rec_hword(rec_r, k_r + 3'd1);
                  end
               end else if (i_start) begin
                  abort_pend_r <= 1'b1;
               end
            end
            ST_NEXT: begin
               if (!i_start) begin
                  ray_count_r <= ray_count_r + 32'd1;
                  rec_addr_r  <= rec_addr_r + ADDR_W'(REC_BYTES);
               end
               state_r <= ST_IDLE;
            end
            default: begin
               write_r <= 1'b0;
               be_r    <= 2'b00;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_ready           = !fifo_full_s;
   assign o_done            = done_r;
   assign avm_m0_write      = write_r;
   assign avm_m0_address    = addr_r;
   assign avm_m0_writedata  = wdata_r;
   assign avm_m0_byteenable = be_r;

endmodule

// File: tb/tb_hit_writer.sv
// Directed self-checking bench for hit_writer; accepted writes are logged on the falling edge.
module tb_hit_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_start;
   logic [31:0] i_baseaddr;
   logic [31:0] i_ray_cnt;
   logic        i_valid;
   logic        o_ready;
   logic        i_hit;
   logic [31:0] i_t;
   logic [31:0] i_tri_index;
   logic        o_done;
   logic        avm_m0_write;
   logic [31:0] avm_m0_address;
   logic [15:0] avm_m0_writedata;
   logic [1:0]  avm_m0_byteenable;
   logic        avm_m0_waitrequest;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int hold_cnt = 0;
   int done_rise_cyc = -1;
   logic done_prev = 1'b0;

   logic [31:0] log_addr [$];
   logic [15:0] log_data [$];
   int          log_cyc  [$];

   hit_writer #(.FIFO_DEPTH(4), .ADDR_W(32)) dut (
      .clk                (clk),
      .reset              (reset),
      .i_start            (i_start),
      .i_baseaddr         (i_baseaddr),
      .i_ray_cnt          (i_ray_cnt),
      .i_valid            (i_valid),
      .o_ready            (o_ready),
      .i_hit              (i_hit),
      .i_t                (i_t),
      .i_tri_index        (i_tri_index),
      .o_done             (o_done),
      .avm_m0_write       (avm_m0_write),
      .avm_m0_address     (avm_m0_address),
      .avm_m0_writedata   (avm_m0_writedata),
      .avm_m0_byteenable  (avm_m0_byteenable),
      .avm_m0_waitrequest (avm_m0_waitrequest)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (avm_m0_write && !avm_m0_waitrequest) begin
         log_addr.push_back(avm_m0_address);
         log_data.push_back(avm_m0_writedata);
         log_cyc.push_back(cyc);
      end
      if (avm_m0_write && avm_m0_address == 32'h0000_0104 && avm_m0_writedata == 16'h0000)
         hold_cnt <= hold_cnt + 1;
      if (o_done && !done_prev)
         done_rise_cyc <= cyc;
      done_prev <= o_done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [31:0] base, input logic [31:0] cnt);
      i_start = 1'b1; i_baseaddr = base; i_ray_cnt = cnt;
      tick();
      i_start = 1'b0;
   endtask

   task automatic push(input logic hit, input logic [31:0] t, input logic [31:0] idx);
      i_valid = 1'b1; i_hit = hit; i_t = t; i_tri_index = idx;
      tick();
      i_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (!o_done && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (o_done !== 1'b1) begin
         errors++;
         $display("FAIL %s_done: o_done=%b after %0d cycles, required 1", name, o_done, n);
      end
   endtask

   task automatic wait_addr(input logic [31:0] a, input int budget, input string name);
      int n = 0;
      while (!(avm_m0_write && avm_m0_address == a) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (!(avm_m0_write === 1'b1 && avm_m0_address === a)) begin
         errors++;
         $display("FAIL %s_reach: write=%b addr=%h, required write at %h", name, avm_m0_write, avm_m0_address, a);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; i_start = 1'b0; i_baseaddr = 32'd0; i_ray_cnt = 32'd0; i_valid = 1'b0;
      i_hit = 1'b0; i_t = 32'd0; i_tri_index = 32'd0; avm_m0_waitrequest = 1'b0;
      tick(); tick();
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", o_ready); end
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", o_done); end
      checks++; if (avm_m0_write !== 1'b0) begin errors++; $display("FAIL rst_write: got %b want 0", avm_m0_write); end
      checks++; if (avm_m0_address !== 32'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", avm_m0_address); end
      checks++; if (avm_m0_writedata !== 16'd0) begin errors++; $display("FAIL rst_data: got %h want 0", avm_m0_writedata); end
      checks++; if (avm_m0_byteenable !== 2'b00) begin errors++; $display("FAIL rst_be: got %b want 00", avm_m0_byteenable); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_hit_record();
      logic [15:0] exp_d [6] = '{16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h0002, 16'h0000};
      int b, pc;
      start_frame(32'h0000_0100, 32'd1);
      b = log_addr.size();
      pc = cyc;
      push(1'b1, 32'h0001_0000, 32'd2);
      wait_done(60, "hit");
      tick();
      checks++;
      if (log_addr.size() - b !== 6) begin
         errors++; $display("FAIL hit_count: got %0d writes want 6", log_addr.size() - b);
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (log_addr[b+i] !== 32'h100 + 32'(2*i)) begin
               errors++; $display("FAIL hit_addr%0d: got %h want %h", i, log_addr[b+i], 32'h100 + 32'(2*i));
            end
            checks++;
            if (log_data[b+i] !== exp_d[i]) begin
               errors++; $display("FAIL hit_data%0d: got %h want %h", i, log_data[b+i], exp_d[i]);
            end
            checks++;
            if (avm_m0_byteenable !== 2'b00 && i == 0) begin
               errors++; $display("FAIL hit_be_idle: got %b want 00", avm_m0_byteenable);
            end
         end
         checks++;
         if (log_cyc[b] - pc !== 2) begin
            errors++; $display("FAIL hit_latency: got %0d cycles want 2", log_cyc[b] - pc);
         end
         checks++;
         if (done_rise_cyc !== log_cyc[b+5] + 1) begin
            errors++; $display("FAIL hit_done_time: got cycle %0d want %0d", done_rise_cyc, log_cyc[b+5] + 1);
         end
      end
   endtask

   task automatic test_miss();
`ifdef HIT_WRITER_COMPACT_MISS_EN
      localparam int N = 2;
`else
      localparam int N = 6;
`endif
      logic [15:0] exp_d [6] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'hFFFF};
      int b;
      start_frame(32'h0000_0100, 32'd1);
      b = log_addr.size();
      push(1'b0, 32'h0000_0005, 32'h0000_0007);
      wait_done(60, "miss");
      tick();
      checks++;
      if (log_addr.size() - b !== N) begin
         errors++; $display("FAIL miss_count: got %0d writes want %0d", log_addr.size() - b, N);
      end else begin
         for (int i = 0; i < N; i++) begin
            checks++;
            if (log_addr[b+i] !== 32'h100 + 32'(2*i) || log_data[b+i] !== exp_d[i]) begin
               errors++;
               $display("FAIL miss_hw%0d: got %h@%h want %h@%h", i, log_data[b+i], log_addr[b+i], exp_d[i], 32'h100 + 32'(2*i));
            end
         end
      end
   endtask

   task automatic test_waitrequest();
      logic [15:0] exp_d [6] = '{16'h0001, 16'h0000, 16'h0000, 16'h1234, 16'h0009, 16'h0000};
      int b, hb;
      start_frame(32'h0000_0100, 32'd1);
      b = log_addr.size();
      push(1'b1, 32'h1234_0000, 32'd9);
      wait_addr(32'h0000_0104, 20, "wr");
      hb = hold_cnt;
      avm_m0_waitrequest = 1'b1;
      repeat (3) tick();
      checks++;
      if (avm_m0_address !== 32'h104 || avm_m0_writedata !== 16'h0000 || avm_m0_write !== 1'b1) begin
         errors++; $display("FAIL wr_stall: got %b %h %h want 1 104 0000", avm_m0_write, avm_m0_address, avm_m0_writedata);
      end
      avm_m0_waitrequest = 1'b0;
      wait_done(60, "wr");
      tick();
      checks++;
      if (hold_cnt - hb !== 4) begin
         errors++; $display("FAIL wr_hold: got %0d cycles want 4", hold_cnt - hb);
      end
      checks++;
      if (log_addr.size() - b !== 6) begin
         errors++; $display("FAIL wr_count: got %0d writes want 6", log_addr.size() - b);
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (log_addr[b+i] !== 32'h100 + 32'(2*i) || log_data[b+i] !== exp_d[i]) begin
               errors++;
               $display("FAIL wr_hw%0d: got %h@%h want %h@%h", i, log_data[b+i], log_addr[b+i], exp_d[i], 32'h100 + 32'(2*i));
            end
         end
      end
   endtask

   task automatic test_fifo_full();
      logic rdy [6];
      int b;
      start_frame(32'h0000_0200, 32'd5);
      b = log_addr.size();
      avm_m0_waitrequest = 1'b1;
      for (int i = 0; i < 6; i++) begin
         i_valid = 1'b1; i_hit = 1'b1; i_t = 32'(i); i_tri_index = 32'(10 + i);
         tick();
         rdy[i] = o_ready;
      end
      i_valid = 1'b0;
      checks++; if (rdy[3] !== 1'b1) begin errors++; $display("FAIL full_rdy4: got %b want 1", rdy[3]); end
      checks++; if (rdy[4] !== 1'b0) begin errors++; $display("FAIL full_rdy5: got %b want 0", rdy[4]); end
      checks++; if (rdy[5] !== 1'b0) begin errors++; $display("FAIL full_rdy6: got %b want 0", rdy[5]); end
      avm_m0_waitrequest = 1'b0;
      wait_done(200, "full");
      tick();
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL full_drain_rdy: got %b want 1", o_ready); end
      checks++;
      if (log_addr.size() - b !== 30) begin
         errors++; $display("FAIL full_count: got %0d writes want 30", log_addr.size() - b);
      end else begin
         for (int n = 0; n < 5; n++) begin
            checks++;
            if (log_addr[b+6*n] !== 32'h200 + 32'(12*n) || log_data[b+6*n+4] !== 16'(10 + n)) begin
               errors++;
               $display("FAIL full_rec%0d: got idx %h@%h want %h@%h", n, log_data[b+6*n+4], log_addr[b+6*n], 16'(10 + n), 32'h200 + 32'(12*n));
            end
         end
      end
   endtask

   task automatic test_wrap();
      int b;
      start_frame(32'hFFFF_FFF4, 32'd3);
      b = log_addr.size();
      push(1'b1, 32'h0000_0001, 32'd1);
      push(1'b1, 32'h0000_0002, 32'd2);
      push(1'b1, 32'h0000_0003, 32'd3);
      wait_done(120, "wrap");
      tick();
      checks++;
      if (log_addr.size() - b !== 18) begin
         errors++; $display("FAIL wrap_count: got %0d writes want 18", log_addr.size() - b);
      end else begin
         checks++; if (log_addr[b+5] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_r0end: got %h want fffffffe", log_addr[b+5]); end
         checks++; if (log_addr[b+6] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_r1: got %h want 00000000", log_addr[b+6]); end
         checks++; if (log_addr[b+12] !== 32'h0000_000C) begin errors++; $display("FAIL wrap_r2: got %h want 0000000c", log_addr[b+12]); end
         checks++; if (log_data[b+16] !== 16'h0003) begin errors++; $display("FAIL wrap_r2idx: got %h want 0003", log_data[b+16]); end
         checks++;
         if (done_rise_cyc !== log_cyc[b+17] + 1) begin
            errors++; $display("FAIL wrap_done_time: got cycle %0d want %0d", done_rise_cyc, log_cyc[b+17] + 1);
         end
      end
   endtask

   task automatic test_start_abort();
      int b;
      start_frame(32'h0000_0100, 32'd2);
      b = log_addr.size();
      push(1'b1, 32'h0003_0000, 32'hAAAA_BBBB);
      push(1'b1, 32'h0000_0000, 32'h1111_2222);
      wait_addr(32'h0000_0106, 20, "abort");
      i_start = 1'b1; i_baseaddr = 32'h0000_0400; i_ray_cnt = 32'd1;
      tick();
      i_start = 1'b0;
      checks++; if (avm_m0_write !== 1'b0) begin errors++; $display("FAIL abort_write: got %b want 0", avm_m0_write); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", o_ready); end
      checks++;
      if (log_addr.size() - b !== 4) begin
         errors++; $display("FAIL abort_count: got %0d writes want 4", log_addr.size() - b);
      end else begin
         checks++;
         if (log_addr[b+3] !== 32'h106 || log_data[b+3] !== 16'h0003) begin
            errors++; $display("FAIL abort_k3: got %h@%h want 0003@00000106", log_data[b+3], log_addr[b+3]);
         end
      end
      b = log_addr.size();
      push(1'b1, 32'h0004_0000, 32'd5);
      wait_done(60, "abort");
      tick();
      checks++;
      if (log_addr.size() - b !== 6) begin
         errors++; $display("FAIL abort_new_count: got %0d writes want 6", log_addr.size() - b);
      end else begin
         checks++; if (log_addr[b] !== 32'h400) begin errors++; $display("FAIL abort_new_base: got %h want 00000400", log_addr[b]); end
         checks++; if (log_data[b+3] !== 16'h0004) begin errors++; $display("FAIL abort_new_t: got %h want 0004", log_data[b+3]); end
         checks++; if (log_data[b+4] !== 16'h0005) begin errors++; $display("FAIL abort_new_idx: got %h want 0005", log_data[b+4]); end
      end
   endtask

   task automatic test_zero_cnt();
      int b;
      start_frame(32'h0000_0300, 32'd0);
      checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", o_done); end
      b = log_addr.size();
      push(1'b1, 32'h0000_0001, 32'h0000_0066);
      repeat (12) tick();
      checks++; if (log_addr.size() - b !== 0) begin errors++; $display("FAIL zero_nowrite: got %0d writes want 0", log_addr.size() - b); end
      checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL zero_hold: got %b want 1", o_done); end
      start_frame(32'h0000_0300, 32'd1);
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL zero_clear: got %b want 0", o_done); end
      push(1'b1, 32'h0000_0001, 32'h0000_0077);
      wait_done(60, "zero");
      tick();
      checks++;
      if (log_addr.size() - b !== 6) begin
         errors++; $display("FAIL zero_count: got %0d writes want 6", log_addr.size() - b);
      end else begin
         checks++; if (log_data[b+4] !== 16'h0077) begin errors++; $display("FAIL zero_discard: got %h want 0077", log_data[b+4]); end
      end
   endtask

   task automatic test_reset_mid_write();
      start_frame(32'h0000_0100, 32'd1);
      push(1'b1, 32'h0000_0001, 32'd1);
      wait_addr(32'h0000_0102, 20, "rstmid");
      #2 reset = 1'b1;
      #1;
      checks++; if (avm_m0_write !== 1'b0) begin errors++; $display("FAIL rstmid_write: got %b want 0", avm_m0_write); end
      checks++; if (avm_m0_byteenable !== 2'b00) begin errors++; $display("FAIL rstmid_be: got %b want 00", avm_m0_byteenable); end
      tick();
      reset = 1'b0;
      tick();
      checks++; if (o_ready !== 1'b1 || o_done !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got ready=%b done=%b want 1 0", o_ready, o_done); end
   endtask

   initial begin
      test_reset();
      test_hit_record();
      test_miss();
      test_waitrequest();
      test_fifo_full();
      test_wrap();
      test_start_abort();
      test_zero_cnt();
      test_reset_mid_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule
